// File: rtl/spi_config_sequencer.sv
// Walks a configuration table and replays each entry to a sensor over an SPI controller:
// writes, read-back verification, timed delays, with timeout and mismatch reporting.
module spi_config_sequencer #(
    parameter int TBL_AW      = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [TBL_AW-1:0] err_idx,
    output logic [1:0]        err_code,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [31:0]       tbl_data,
    output logic              spi_start,
    output logic [25:0]       spi_upload_data,
    input  logic [15:0]       spi_read_data,
    input  logic              spi_done
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;

    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        XFER,
        CHECK,
        WAIT,
        DONE,
        ERROR
    } state_t;

    state_t            state_reg;
    logic [TBL_AW-1:0] index_reg;
    logic [1:0]        op_reg;
    logic [15:0]       data_reg;
    logic [15:0]       delay_reg;
    logic [TW-1:0]     timeout_reg;
    logic              last_entry;
    logic              unused_fields;

    // The table read port is registered, so the index itself serves as the address.
    assign tbl_addr      = index_reg;
    assign last_entry    = &index_reg;
    assign unused_fields = ^tbl_data[29:25];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            index_reg       <= '0;
            op_reg          <= '0;
            data_reg        <= '0;
            delay_reg       <= '0;
            timeout_reg     <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            err_idx         <= '0;
            err_code        <= '0;
            spi_start       <= 1'b0;
            spi_upload_data <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        index_reg <= '0;
                        error     <= 1'b0;
                        err_code  <= '0;
                        err_idx   <= '0;
                        busy      <= 1'b1;
                        state_reg <= FETCH;
                    end
                end

                FETCH: state_reg <= DECODE;

                DECODE: begin
                    case (tbl_data[31:30])
                        OP_WRITE, OP_READ: begin
                            op_reg          <= tbl_data[31:30];
                            data_reg        <= tbl_data[15:0];
                            spi_upload_data <= {tbl_data[24:16], (tbl_data[31:30] == OP_WRITE), tbl_data[15:0]};
                            spi_start       <= 1'b1;
                            timeout_reg     <= '0;
                            state_reg       <= XFER;
                        end
                        OP_DELAY: begin
                            delay_reg <= tbl_data[15:0];
                            state_reg <= WAIT;
                        end
                        default: begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= DONE;
                        end
                    endcase
                end

                XFER: begin
                    if (spi_done) begin
                        spi_start <= 1'b0;
                        if (op_reg == OP_WRITE) begin
                            if (last_entry) begin
                                done      <= 1'b1;
                                busy      <= 1'b0;
                                state_reg <= DONE;
                            end else begin
                                index_reg <= index_reg + 1'b1;
                                state_reg <= FETCH;
                            end
                        end else begin
                            state_reg <= CHECK;
                        end
                    end else if (timeout_reg == TW'(TIMEOUT_CYC - 1)) begin
                        spi_start <= 1'b0;
                        err_code  <= ERR_TIMEOUT;
                        err_idx   <= index_reg;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= ERROR;
                    end else begin
                        timeout_reg <= timeout_reg + 1'b1;
                    end
                end

                CHECK: begin
                    if (spi_read_data == data_reg) begin
                        if (last_entry) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= DONE;
                        end else begin
                            index_reg <= index_reg + 1'b1;
                            state_reg <= FETCH;
                        end
                    end else begin
                        err_code  <= ERR_MISMATCH;
                        err_idx   <= index_reg;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= ERROR;
                    end
                end

                // A delay of N spends N+1 cycles here, so a zero delay still costs one cycle.
                WAIT: begin
                    if (delay_reg == '0) begin
                        if (last_entry) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= DONE;
                        end else begin
                            index_reg <= index_reg + 1'b1;
                            state_reg <= FETCH;
                        end
                    end else begin
                        delay_reg <= delay_reg - 1'b1;
                    end
                end

                DONE:  state_reg <= IDLE;

                ERROR: state_reg <= IDLE;

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_config_sequencer.sv
// Directed bench for spi_config_sequencer: table-driven scenarios with a behavioural
// SPI controller and table ROM, plus hand-written timing and reset sequences.
module tb_spi_config_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  err_idx;
    logic [1:0]  err_code;
    logic [7:0]  tbl_addr;
    logic [31:0] tbl_data;
    logic        spi_start;
    logic [25:0] spi_upload_data;
    logic [15:0] spi_read_data;
    logic        spi_done;

    always #5 clk = ~clk;

    spi_config_sequencer #(
        .TBL_AW      (8),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .err_idx         (err_idx),
        .err_code        (err_code),
        .tbl_addr        (tbl_addr),
        .tbl_data        (tbl_data),
        .spi_start       (spi_start),
        .spi_upload_data (spi_upload_data),
        .spi_read_data   (spi_read_data),
        .spi_done        (spi_done)
    );

    localparam logic [1:0]  OP_W  = 2'b00;
    localparam logic [1:0]  OP_R  = 2'b01;
    localparam logic [1:0]  OP_D  = 2'b10;
    localparam logic [31:0] END_W = 32'hC000_0000;

    // Table ROM with one cycle of read latency.
    logic [31:0] tbl_mem [0:255];
    always @(posedge clk) tbl_data <= tbl_mem[tbl_addr];

    // SPI controller model: answers each spi_start episode after model_delay cycles.
    int          model_delay = 30;
    bit          model_never = 1'b0;
    logic [15:0] model_rdata = 16'h0;
    logic        model_done  = 1'b0;
    logic        force_done  = 1'b0;
    bit          active      = 1'b0;
    int          cnt         = 0;
    int          len         = 0;
    int          episodes    = 0;
    int          unstable    = 0;
    int          done_pulses = 0;
    logic [25:0] last_upload = '0;

    assign spi_done      = model_done | force_done;
    assign spi_read_data = model_rdata;

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (spi_start) begin
            if (!active) begin
                active      <= 1'b1;
                cnt         <= 1;
                len         <= 1;
                episodes    <= episodes + 1;
                last_upload <= spi_upload_data;
            end else begin
                cnt <= cnt + 1;
                len <= len + 1;
                if (spi_upload_data != last_upload) unstable <= unstable + 1;
            end
            if (active && !model_never && cnt == model_delay) model_done <= 1'b1;
        end else begin
            active <= 1'b0;
        end
        if (done) done_pulses <= done_pulses + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [1:0] op, input logic [8:0] addr, input logic [15:0] data);
        return {op, 5'b0, addr, data};
    endfunction

    task automatic load_table(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        for (int i = 0; i < 256; i++) tbl_mem[i] = END_W;
        tbl_mem[0] = w0;
        tbl_mem[1] = w1;
        tbl_mem[2] = w2;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_finish(input string name);
        int cyc;
        cyc = 0;
        while (!(done || error) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_finish_in_bound"}, 32'(cyc < 3000), 32'd1);
    endtask

    // Cycles from the start-accepting edge until spi_start is seen high.
    task automatic measure_start(output int cyc, input bit poke_done);
        cyc = 0;
        while (!spi_start && cyc < 200) begin
            @(negedge clk);
            cyc++;
            force_done = poke_done && (cyc == 4 || cyc == 6);
        end
        force_done = 1'b0;
    endtask

    typedef struct {
        logic [31:0] w0, w1, w2;
        int          delay;
        logic [15:0] rdata;
        bit          never;
        int          exp_done;
        bit          exp_err;
        logic [1:0]  exp_code;
        logic [7:0]  exp_idx;
        int          exp_eps;
        logic [25:0] exp_upload;
        int          exp_len;
    } vec_t;

    task automatic run_vec(input int n, input vec_t v);
        int eps0, dp0, un0;
        string nm;
        nm = $sformatf("vec%0d", n);
        load_table(v.w0, v.w1, v.w2);
        model_delay = v.delay;
        model_never = v.never;
        model_rdata = v.rdata;
        eps0 = episodes;
        dp0  = done_pulses;
        un0  = unstable;
        pulse_start();
        check({nm, "_busy_on_start"}, 32'(busy), 32'd1);
        check({nm, "_error_cleared"}, 32'(error), 32'd0);
        wait_finish(nm);
        repeat (3) @(negedge clk);
        check({nm, "_done_pulses"}, 32'(done_pulses - dp0), 32'(v.exp_done));
        check({nm, "_error"}, 32'(error), 32'(v.exp_err));
        check({nm, "_err_code"}, 32'(err_code), 32'(v.exp_code));
        if (v.exp_err) check({nm, "_err_idx"}, 32'(err_idx), 32'(v.exp_idx));
        check({nm, "_episodes"}, 32'(episodes - eps0), 32'(v.exp_eps));
        check({nm, "_upload"}, 32'(last_upload), 32'(v.exp_upload));
        check({nm, "_upload_stable"}, 32'(unstable - un0), 32'd0);
        check({nm, "_busy_end"}, 32'(busy), 32'd0);
        check({nm, "_spi_start_end"}, 32'(spi_start), 32'd0);
        if (v.exp_len != 0) check({nm, "_start_len"}, 32'(len), 32'(v.exp_len));
        $display("%s: done_pulses=%0d error=%0b code=%0b idx=%0d episodes=%0d upload=0x%07h",
                 nm, done_pulses - dp0, error, err_code, err_idx, episodes - eps0, last_upload);
    endtask

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int cyc, eps0, dp0;

        vecs[0] = '{wd(OP_W, 9'h010, 16'h1234), END_W, END_W, 30, 16'h0000, 1'b0,
                    1, 1'b0, 2'b00, 8'd0, 1, {9'h010, 1'b1, 16'h1234}, 0};
        vecs[1] = '{wd(OP_R, 9'h020, 16'hBEEF), END_W, END_W, 3, 16'hBEEF, 1'b0,
                    1, 1'b0, 2'b00, 8'd0, 1, {9'h020, 1'b0, 16'hBEEF}, 0};
        vecs[2] = '{wd(OP_R, 9'h020, 16'hBEEF), END_W, END_W, 3, 16'hBEEE, 1'b0,
                    0, 1'b1, 2'b01, 8'd0, 1, {9'h020, 1'b0, 16'hBEEF}, 0};
        vecs[3] = '{wd(OP_W, 9'h001, 16'h0001), wd(OP_R, 9'h003, 16'h00FF), END_W, 2, 16'h00FE, 1'b0,
                    0, 1'b1, 2'b01, 8'd1, 2, {9'h003, 1'b0, 16'h00FF}, 0};
        vecs[4] = '{wd(OP_W, 9'h010, 16'h1234), END_W, END_W, 0, 16'h0000, 1'b1,
                    0, 1'b1, 2'b10, 8'd0, 1, {9'h010, 1'b1, 16'h1234}, 64};
        vecs[5] = '{wd(OP_W, 9'h1FF, 16'hFFFF), wd(OP_W, 9'h000, 16'h0000), END_W, 1, 16'h0000, 1'b0,
                    1, 1'b0, 2'b00, 8'd0, 2, {9'h000, 1'b1, 16'h0000}, 0};
        vecs[6] = '{wd(OP_D, 9'h000, 16'h0003), wd(OP_W, 9'h005, 16'h00AA), END_W, 0, 16'h0000, 1'b1,
                    0, 1'b1, 2'b10, 8'd1, 1, {9'h005, 1'b1, 16'h00AA}, 64};
        vecs[7] = '{wd(OP_W, 9'h002, 16'h0002), wd(OP_R, 9'h002, 16'h0002), END_W, 5, 16'h0002, 1'b0,
                    1, 1'b0, 2'b00, 8'd0, 2, {9'h002, 1'b0, 16'h0002}, 0};

        load_table(END_W, END_W, END_W);
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_err_code", 32'(err_code), 32'd0);
        check("reset_err_idx", 32'(err_idx), 32'd0);
        check("reset_tbl_addr", 32'(tbl_addr), 32'd0);
        check("reset_spi_start", 32'(spi_start), 32'd0);
        check("reset_upload", 32'(spi_upload_data), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Fetch latency without a delay, then a DELAY 5 entry with stray spi_done pulses in WAIT.
        load_table(wd(OP_W, 9'h001, 16'h0001), END_W, END_W);
        model_never = 1'b0;
        model_delay = 2;
        pulse_start();
        measure_start(cyc, 1'b0);
        check("fetch_latency", 32'(cyc), 32'd2);
        wait_finish("fetch_latency");
        repeat (3) @(negedge clk);
        $display("fetch_latency: spi_start after %0d cycles", cyc);

        load_table(wd(OP_D, 9'h000, 16'h0005), wd(OP_W, 9'h001, 16'h0001), END_W);
        eps0 = episodes;
        dp0  = done_pulses;
        pulse_start();
        measure_start(cyc, 1'b1);
        check("delay5_latency", 32'(cyc), 32'd10);
        wait_finish("delay5");
        repeat (3) @(negedge clk);
        check("delay5_done", 32'(done_pulses - dp0), 32'd1);
        check("delay5_episodes", 32'(episodes - eps0), 32'd1);
        check("delay5_error", 32'(error), 32'd0);
        check("delay5_upload", 32'(last_upload), 32'({9'h001, 1'b1, 16'h0001}));
        $display("delay5: spi_start after %0d cycles, done_pulses=%0d", cyc, done_pulses - dp0);

        // Reset in the middle of a transfer, then a clean restart.
        load_table(wd(OP_W, 9'h010, 16'h1234), wd(OP_W, 9'h011, 16'h5678), END_W);
        model_never = 1'b1;
        pulse_start();
        measure_start(cyc, 1'b0);
        check("rst_xfer_reached", 32'(spi_start), 32'd1);
        repeat (5) @(negedge clk);
        dp0   = done_pulses;
        reset = 1'b1;
        @(negedge clk);
        check("rst_spi_start_drop", 32'(spi_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_no_done", 32'(done_pulses - dp0), 32'd0);
        check("rst_no_error", 32'(error), 32'd0);
        check("rst_spi_start_low", 32'(spi_start), 32'd0);
        model_never = 1'b0;
        model_delay = 4;
        eps0 = episodes;
        dp0  = done_pulses;
        pulse_start();
        check("restart_tbl_addr", 32'(tbl_addr), 32'd0);
        wait_finish("restart");
        repeat (3) @(negedge clk);
        check("restart_done", 32'(done_pulses - dp0), 32'd1);
        check("restart_episodes", 32'(episodes - eps0), 32'd2);
        check("restart_error", 32'(error), 32'd0);
        check("restart_upload", 32'(last_upload), 32'({9'h011, 1'b1, 16'h5678}));
        $display("restart: done_pulses=%0d episodes=%0d", done_pulses - dp0, episodes - eps0);

        // Full table of zero delays: must finish at the last index, not wrap.
        for (int i = 0; i < 256; i++) tbl_mem[i] = wd(OP_D, 9'h000, 16'h0000);
        eps0 = episodes;
        dp0  = done_pulses;
        pulse_start();
        wait_finish("wrap");
        repeat (5) @(negedge clk);
        check("wrap_done", 32'(done_pulses - dp0), 32'd1);
        check("wrap_busy", 32'(busy), 32'd0);
        check("wrap_error", 32'(error), 32'd0);
        check("wrap_episodes", 32'(episodes - eps0), 32'd0);
        $display("wrap: done_pulses=%0d busy=%0b", done_pulses - dp0, busy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
